// File: rtl/cmp_lut_pkg.sv
// Shared constants, entry bit positions and FSM state encoding for the comparator LUT writer.
package cmp_lut_pkg;
    localparam int OPW   = 2;
    localparam int AW    = 2 * OPW;
    localparam int DEPTH = 2 ** AW;

    localparam int GT_BIT = 2;
    localparam int EQ_BIT = 1;
    localparam int LT_BIT = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/cmp_lut_writer_if.sv
// Control-side and RAM-side signals of the LUT writer; the readback pair exists only with CMP_LUT_CHECK_EN.
interface cmp_lut_writer_if;
    import cmp_lut_pkg::*;

    logic          start;
    logic          ext_valid;
    logic          ext_ready;
    logic [AW-1:0] ext_addr;
    logic [2:0]    ext_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          busy;
    logic          done;
    logic          err;
`ifdef CMP_LUT_CHECK_EN
    logic [AW-1:0] rd_addr;
    logic [2:0]    rd_data;

    modport master (
        output start, ext_valid, ext_addr, ext_data, rd_data,
        input  ext_ready, wr_en, wr_addr, wr_data, busy, done, err, rd_addr
    );
    modport slave (
        input  start, ext_valid, ext_addr, ext_data, rd_data,
        output ext_ready, wr_en, wr_addr, wr_data, busy, done, err, rd_addr
    );
`else
    modport master (
        output start, ext_valid, ext_addr, ext_data,
        input  ext_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
    modport slave (
        input  start, ext_valid, ext_addr, ext_data,
        output ext_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
`endif
endinterface

// File: rtl/cmp_lut_entry_gen.sv
// Combinational {gt,eq,lt} entry for LUT address {a,b}; zero latency, no handshake.
module cmp_lut_entry_gen
    import cmp_lut_pkg::*;
(
    input  logic [AW-1:0] i_addr,
    output logic [2:0]    o_entry
);
    logic [OPW-1:0] w_a;
    logic [OPW-1:0] w_b;

    assign w_a = i_addr[AW-1:OPW];
    assign w_b = i_addr[OPW-1:0];

    always_comb begin
        o_entry         = '0;
        o_entry[GT_BIT] = (w_a > w_b);
        o_entry[EQ_BIT] = (w_a == w_b);
        o_entry[LT_BIT] = (w_a < w_b);
    end
endmodule

// File: rtl/cmp_lut_writer.sv
// LUT RAM writer: start-triggered 16-entry sweep plus single external writes; outputs registered, first write 1 cycle after start.
// ext_ready drops during the sweep and whenever start is high. CMP_LUT_CHECK_EN adds a readback VERIFY pass driving err.
module cmp_lut_writer
    import cmp_lut_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    cmp_lut_writer_if.slave  bus
);
    state_t        r_state;
    logic [AW:0]   r_cnt;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [2:0]    r_wr_data;
    logic          r_busy;
    logic          r_done;

    logic [AW-1:0] w_gen_addr;
    logic [2:0]    w_gen_entry;
    logic          w_ext_ready;
    logic          w_ext_fire;
    logic          w_sweep_end;

`ifdef CMP_LUT_CHECK_EN
    logic          r_err;
    logic          r_cmp_vld;
    logic [AW-1:0] r_cmp_addr;
`endif

    cmp_lut_entry_gen u_entry_gen (
        .i_addr  (w_gen_addr),
        .o_entry (w_gen_entry)
    );

    // Outside FILL/VERIFY the generator sits at address 0, which is exactly the
    // entry needed for the write issued on the start edge.
    always_comb begin
        w_gen_addr = '0;
        if (r_state == FILL) begin
            w_gen_addr = r_cnt[AW-1:0];
        end
`ifdef CMP_LUT_CHECK_EN
        else if (r_state == VERIFY) begin
            w_gen_addr = r_cmp_addr;
        end
`endif
    end

    assign w_ext_ready = (r_state != FILL) && (r_state != VERIFY) && !bus.start;
    assign w_ext_fire  = bus.ext_valid && w_ext_ready;
    assign w_sweep_end = (r_cnt == (AW+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef CMP_LUT_CHECK_EN
            r_err      <= 1'b0;
            r_cmp_vld  <= 1'b0;
            r_cmp_addr <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state   <= FILL;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                        r_wr_data <= w_gen_entry;
                        r_cnt     <= (AW+1)'(1);
`ifdef CMP_LUT_CHECK_EN
                        r_err     <= 1'b0;
`endif
                    end else if (w_ext_fire) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= bus.ext_addr;
                        r_wr_data <= bus.ext_data;
                    end
                end
                FILL: begin
                    if (w_sweep_end) begin
                        r_cnt <= '0;
`ifdef CMP_LUT_CHECK_EN
                        r_state   <= VERIFY;
                        r_cmp_vld <= 1'b0;
`else
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt[AW-1:0];
                        r_wr_data <= w_gen_entry;
                        r_cnt     <= r_cnt + (AW+1)'(1);
                    end
                end
                VERIFY: begin
`ifdef CMP_LUT_CHECK_EN
                    // rd_data answers the address issued one cycle earlier (r_cmp_addr).
                    if (r_cmp_vld && (bus.rd_data != w_gen_entry)) begin
                        r_err <= 1'b1;
                    end
                    r_cmp_addr <= r_cnt[AW-1:0];
                    r_cmp_vld  <= !w_sweep_end;
                    if (w_sweep_end) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + (AW+1)'(1);
                    end
`else
                    r_state <= IDLE;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ext_ready = w_ext_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
`ifdef CMP_LUT_CHECK_EN
    assign bus.err       = r_err;
    assign bus.rd_addr   = r_cnt[AW-1:0];
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_cmp_lut_writer.sv
// Bench for cmp_lut_writer: sweep, external writes, start/ext collision, restart, mid-sweep reset, optional readback error.
`timescale 1ns/1ps
module tb_cmp_lut_writer;
    import cmp_lut_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cmp_lut_writer_if bus ();

    cmp_lut_writer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0] mem    [DEPTH];
    logic [2:0] shadow [DEPTH];
    bit         exp_err;

    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    end

`ifdef CMP_LUT_CHECK_EN
    bit corrupt = 1'b0;
    always @(posedge clk) begin
        bus.rd_data <= (corrupt && bus.rd_addr == 4'd9) ? 3'b010 : mem[bus.rd_addr];
    end
    localparam int EXP_BUSY = 2 * DEPTH + 1;
`else
    localparam int EXP_BUSY = DEPTH;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    data;
    } vec_t;
    vec_t vecs [7];

    // Comparator semantics straight from the definition: a is the high half, b the low half.
    function automatic logic [2:0] ref_entry(input int addr);
        int a, b;
        a = addr / (1 << OPW);
        b = addr % (1 << OPW);
        return {a > b, a == b, a < b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pulses start (optionally with a colliding ext request) and watches the whole sweep.
    task automatic sweep(input bit with_ext, input int restart_at, input string tag);
        int nwr, nbusy, cyc;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.ext_valid = with_ext;
        bus.ext_addr  = 4'h3;
        bus.ext_data  = 3'b101;
        #1;
        chk({tag, "_ready_during_start"}, 32'(bus.ext_ready), 32'(0));
        @(negedge clk);
        bus.start     = 1'b0;
        bus.ext_valid = 1'b0;
        nwr = 0; nbusy = 0; cyc = 0;
        while (!bus.done && cyc < 80) begin
            if (bus.busy) nbusy++;
            if (bus.wr_en) begin
                chk({tag, "_write"}, 32'({bus.wr_addr, bus.wr_data}),
                    32'({nwr[AW-1:0], ref_entry(nwr)}));
                nwr++;
            end
            if (cyc == 3) chk({tag, "_ready_in_fill"}, 32'(bus.ext_ready), 32'(0));
            bus.start = (cyc == restart_at);
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_write_count"}, 32'(nwr), 32'(DEPTH));
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(EXP_BUSY));
        chk({tag, "_end_flags"}, 32'({bus.done, bus.busy, bus.wr_en}), 32'(3'b100));
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    endtask

    logic          pend;
    logic [AW-1:0] pa;
    logic [2:0]    pd;
    logic          v;
    logic [AW-1:0] ra;
    logic [2:0]    rd;

    initial begin
        vecs[0] = '{addr: 4'h0, data: 3'b010};
        vecs[1] = '{addr: 4'h4, data: 3'b100};
        vecs[2] = '{addr: 4'h1, data: 3'b001};
        vecs[3] = '{addr: 4'hF, data: 3'b010};
        vecs[4] = '{addr: 4'h9, data: 3'b100};
        vecs[5] = '{addr: 4'h6, data: 3'b001};
        vecs[6] = '{addr: 4'hA, data: 3'b010};

        bus.start = 1'b0; bus.ext_valid = 1'b0; bus.ext_addr = '0; bus.ext_data = '0;
        exp_err = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({bus.wr_en, bus.busy, bus.done, bus.err}), 32'(0));
        chk("reset_wr_bus", 32'({bus.wr_addr, bus.wr_data}), 32'(0));
        chk("reset_ready", 32'(bus.ext_ready), 32'(1));
        rst_n = 1'b1;
        @(negedge clk);

        sweep(1'b0, -1, "sweep1");
        for (int i = 0; i < 7; i++) begin
            chk("table_entry", 32'({vecs[i].addr, mem[vecs[i].addr]}),
                32'({vecs[i].addr, vecs[i].data}));
        end

        // External write while DONE.
        bus.ext_valid = 1'b1; bus.ext_addr = 4'h6; bus.ext_data = 3'b111;
        #1;
        chk("ext_ready_done", 32'(bus.ext_ready), 32'(1));
        @(negedge clk);
        bus.ext_valid = 1'b0;
        chk("ext_write", 32'({bus.wr_en, bus.wr_addr, bus.wr_data, bus.done}),
            32'({1'b1, 4'h6, 3'b111, 1'b1}));
        @(negedge clk);
        chk("ext_write_single", 32'(bus.wr_en), 32'(0));

        // Random external traffic scored against a shadow of the RAM contents.
        for (int i = 0; i < DEPTH; i++) shadow[i] = ref_entry(i);
        shadow[6] = 3'b111;
        pend = 1'b0; pa = '0; pd = '0;
        for (int i = 0; i < 40; i++) begin
            if (pend) chk("rand_write", 32'({bus.wr_en, bus.wr_addr, bus.wr_data}), 32'({1'b1, pa, pd}));
            else      chk("rand_idle", 32'(bus.wr_en), 32'(0));
            v  = 1'($urandom_range(0, 1));
            ra = AW'($urandom);
            rd = 3'($urandom);
            bus.ext_valid = v; bus.ext_addr = ra; bus.ext_data = rd;
            pend = v; pa = ra; pd = rd;
            if (v) shadow[ra] = rd;
            @(negedge clk);
        end
        bus.ext_valid = 1'b0;
        if (pend) chk("rand_write", 32'({bus.wr_en, bus.wr_addr, bus.wr_data}), 32'({1'b1, pa, pd}));
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ram_contents", 32'({i[AW-1:0], mem[i]}), 32'({i[AW-1:0], shadow[i]}));
        end
        chk("done_sticky", 32'(bus.done), 32'(1));

        // start and ext_valid together from IDLE: start wins.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sweep(1'b1, -1, "start_vs_ext");

        // Second start mid-sweep is ignored.
        sweep(1'b0, 5, "restart_ignored");

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("midfill_pre", 32'({bus.wr_en, bus.busy}), 32'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        chk("midfill_async", 32'({bus.wr_en, bus.busy, bus.done}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midfill_idle", 32'({bus.ext_ready, bus.busy}), 32'(2'b10));
        sweep(1'b0, -1, "after_reset");

`ifdef CMP_LUT_CHECK_EN
        corrupt = 1'b1;
        exp_err = 1'b1;
        sweep(1'b0, -1, "verify_bad");
        corrupt = 1'b0;
        exp_err = 1'b0;
        sweep(1'b0, -1, "verify_clean");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
